// File: rtl/sr_drive_pkg.sv
// Package sr_drive_pkg
// Shared definitions for the S/R drive sequencer: op encodings, FSM state
// encoding, default timing constants and the op-to-target helper.
package sr_drive_pkg;

   typedef enum logic [1:0] {
      OP_HOLD   = 2'b00,
      OP_SET    = 2'b01,
      OP_RESET  = 2'b10,
      OP_TOGGLE = 2'b11
   } sr_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_PULSE  = 2'b01,
      ST_SETTLE = 2'b10,
      ST_DONE   = 2'b11
   } sr_state_e;

   localparam int PULSE_CYCLES_DEF  = 2;
   localparam int SETTLE_CYCLES_DEF = 1;
   localparam int CNT_W_DEF         = 4;

   // Level the flip-flop should hold once the op completes, given Q at accept.
   function automatic logic op_target(input logic [1:0] op, input logic q);
      logic t;
      case (op)
         OP_SET:    t = 1'b1;
         OP_RESET:  t = 1'b0;
         OP_TOGGLE: t = ~q;
         default:   t = q;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Module sr_pulse_timer
// Loadable down-counter shared by the PULSE and SETTLE phases.
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset (count -> 0)
//   load      : load load_val this cycle (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one, saturating at zero
//   zero      : count is zero
module sr_pulse_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/sr_drive_sequencer.sv
// Module sr_drive_sequencer
// Accepts one op per handshake and drives a timed S or R pulse into a clocked
// SR flip-flop, then checks the Q/Qbar feedback against the op's target.
// Ports:
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready/req_op : op request handshake (HOLD/SET/RESET/TOGGLE)
//   S, R           : registered drive to the flip-flop, never both high
//   Q, Qbar        : flip-flop feedback
//   done           : one-cycle completion pulse
//   err            : qualified by done; Q missed target or Q==Qbar
//   err_sticky     : OR of every err since reset
//   dbg_state      : current FSM state
// Build option: SR_SKIP_REDUNDANT_EN -- SET/RESET whose target already
// equals Q at accept complete in one cycle without pulsing.
//
// Handshake: an op is accepted on a rising edge where req_valid and
// req_ready are both 1; req_op is only looked at on that edge. req_ready is
// high only in IDLE, so at most one op is in flight.
module sr_drive_sequencer
   import sr_drive_pkg::*;
#(
   parameter int PULSE_CYCLES  = PULSE_CYCLES_DEF,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
   parameter int CNT_W         = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   output logic       S,
   output logic       R,
   input  logic       Q,
   input  logic       Qbar,
   output logic       done,
   output logic       err,
   output logic       err_sticky,
   output sr_state_e  dbg_state
);

   localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

   sr_state_e        state, state_nxt;
   logic             target_q, target_nxt;
   logic             s_nxt, r_nxt, ready_nxt, done_nxt, err_nxt, sticky_nxt;
   logic             tmr_load, tmr_dec, tmr_zero;
   logic [CNT_W-1:0] tmr_load_val;
   logic             accept, acc_target, skip;

   sr_pulse_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   assign accept     = req_valid & req_ready;
   assign acc_target = op_target(req_op, Q);

`ifdef SR_SKIP_REDUNDANT_EN
   // TOGGLE always differs from Q, so only SET/RESET can be redundant.
   assign skip = (req_op != OP_TOGGLE) && (acc_target == Q);
`else
   assign skip = 1'b0;
`endif

   always_comb begin
      state_nxt    = state;
      target_nxt   = target_q;
      s_nxt        = 1'b0;
      r_nxt        = 1'b0;
      ready_nxt    = 1'b0;
      done_nxt     = 1'b0;
      err_nxt      = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_dec      = 1'b0;
      case (state)
         ST_IDLE: begin
            ready_nxt = 1'b1;
            if (accept) begin
               ready_nxt  = 1'b0;
               target_nxt = acc_target;
               if ((req_op == OP_HOLD) || skip) begin
                  // Nothing to drive: Q/Qbar at accept decide err.
                  state_nxt = ST_DONE;
                  done_nxt  = 1'b1;
                  err_nxt   = (Q != acc_target) | (Q == Qbar);
               end else begin
                  // S and R derive from one bit and its complement, so they
                  // can never both be high.
                  state_nxt    = ST_PULSE;
                  s_nxt        = acc_target;
                  r_nxt        = ~acc_target;
                  tmr_load     = 1'b1;
                  tmr_load_val = PULSE_LD;
               end
            end
         end
         ST_PULSE: begin
            if (tmr_zero) begin
               state_nxt    = ST_SETTLE;
               tmr_load     = 1'b1;
               tmr_load_val = SETTLE_LD;
            end else begin
               s_nxt   = S;
               r_nxt   = R;
               tmr_dec = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (tmr_zero) begin
               state_nxt = ST_DONE;
               done_nxt  = 1'b1;
               err_nxt   = (Q != target_q) | (Q == Qbar);
            end else begin
               tmr_dec = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            ready_nxt = 1'b1;
         end
      endcase
      sticky_nxt = err_sticky | err_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         target_q   <= 1'b0;
         S          <= 1'b0;
         R          <= 1'b0;
         req_ready  <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         state      <= state_nxt;
         target_q   <= target_nxt;
         S          <= s_nxt;
         R          <= r_nxt;
         req_ready  <= ready_nxt;
         done       <= done_nxt;
         err        <= err_nxt;
         err_sticky <= sticky_nxt;
      end
   end

   assign dbg_state = state;

endmodule
